ctrl_pipeline: RTL and testbench
================================

# ctrl_pipeline

Carries the 10-bit main-control word from decode through the EX, MEM and WB pipeline registers and splits it into per-stage control fields. Also holds the register specifiers needed for hazard handling. The block detects RAW hazards against in-flight instructions, inserts bubbles, and applies branch/jump flushes. It sits between the combinational opcode decoder and the datapath stage muxes and is the consumer end of the control-word interface.

## Interface
- `XLEN_REG`, default 5: register-specifier width.
- `CTRL_W`, default 10: control-word width. The layout is {ALUOp[9:8], MemtoReg[7:6], Branch[5], MemRead[4], MemWrite[3], ALUSrc[2], Jump[1], RegWrite[0]}.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `id_ctrl`, in, 10: control word of the instruction currently in ID.
- `id_rs1`, `id_rs2`, `id_rd`, in, 5 each: register specifiers of the ID instruction.
- `flush`, in, 1: branch/jump taken, resolved in EX. Kills the ID instruction.
- `stall`, out, 1: combinational. Holds the PC and the IF/ID register.
- `ex_alu_op` (2), `ex_alu_src`, `ex_branch`, `ex_jump`, out: EX-stage fields.
- `mem_read`, `mem_write`, out, 1 each: MEM-stage fields.
- `wb_memtoreg` (2), `wb_regwrite`, `wb_rd` (5), out: WB-stage fields.
- `fwd_a`, `fwd_b`, out, 2 each: EX operand source. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.

## Operation
- Three stage registers, EX, MEM and WB, each holding the control fields still needed downstream plus rd.
  - EX also holds rs1 and rs2.
  - A bubble is an all-zero control word with rd = 0.
- Each cycle:
  - EX ← ID when there is no stall and no flush; otherwise EX ← bubble.
  - MEM ← EX and WB ← MEM always. Downstream stages never stall.
- A hazard match requires a nonzero rd equal to id_rs1 or id_rs2.
  - Both sources are compared regardless of instruction format, which is conservative.
  - x0 never matches.
- Stall condition with forwarding: EX-stage MemRead=1 and a match (load-use). This costs exactly one bubble.
- Stall condition without forwarding: a match against EX with RegWrite=1, or a match against MEM with RegWrite=1.
  - A match against WB never stalls, because the register file is write-before-read.
- Forwarding priority for each operand:
  - 10 when MEM RegWrite=1, MEM rd≠0 and MEM rd matches the EX rs.
  - Otherwise 01 when the same conditions hold in WB.
  - Otherwise 00.
- Flush and stall in the same cycle: flush wins and `stall` is forced to 0, because the ID instruction is discarded and need not be held.

## Timing
- Reset: all stage registers are cleared asynchronously. Every output is 0, including `stall`, `fwd_a`, `fwd_b` and `wb_rd`.
- The first edge after reset release loads normally.
- Latency: an ID control word appears on the EX outputs 1 cycle later, the MEM outputs 2 cycles later and the WB outputs 3 cycles later.
- `stall` and `flush` act at the next edge. The IF/ID hold is the consumer's duty.
- Reset asserted mid-operation: all in-flight instructions are dropped immediately with no partial writeback. The next WB output is a bubble.
- `stall` and `fwd_*` are combinational from the stage registers and the ID inputs. They are valid in the same cycle.

## Configuration
- `CTRL_FORWARD_EN` defined: forwarding comparators are built, `fwd_a`/`fwd_b` are live, and only load-use stalls occur.
- `CTRL_FORWARD_EN` undefined:
  - `fwd_a`/`fwd_b` are tied to 00 and the ports remain.
  - The EX register does not store rs1/rs2.
  - The full EX/MEM RegWrite-match stall rule applies, with up to 2 stall cycles per dependency.

## Structure
- Package `ctrl_pkg` holds:
  - control-word bit-position constants;
  - ALUOp encodings: 00 add, 01 branch compare, 10 R-type, 11 I-type;
  - MemtoReg encodings;
  - forward-select encodings;
  - the bubble constant.
- Sub-module `ctrl_hazard` is purely combinational. It takes stage rd/RegWrite/MemRead and the rs values and produces `stall`, `fwd_a` and `fwd_b`. The top module owns the stage registers.

## Test plan
- Reset: assert `rst` mid-stream with a load in MEM → all outputs 0 immediately. After release, the first WB output is a bubble and `wb_regwrite`=0.
- Passthrough: issue R-type ctrl 10_11_0_0_0_0_0_1 with rd=5 → `ex_alu_op`=10 at +1, `mem_read`/`mem_write`=0 at +2, `wb_regwrite`=1 with `wb_rd`=5 at +3.
- Load-use, forwarding on: issue `lw` with rd=7, then `add` with rs1=7 → `stall`=1 for exactly one cycle and the EX outputs show a bubble. When `add` reaches EX, `fwd_a`=01.
- Forward priority: issue `addi` writing x3 twice in a row, then a consumer with rs2=3 → `fwd_b`=10, meaning the newest value is selected. A consumer with rs1=0 after a writer of x0 → `fwd_a`=00.
- Flush plus stall: a load-use condition and `flush`=1 in the same cycle → `stall`=0 and the EX stage receives a bubble on the next edge.
- No-forward build: issue `addi` with rd=4, then a use of x4 → `stall`=1 for 2 cycles, then 0 with `fwd_a`=00.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Control-word layout, field encodings and bubble constant shared
//            by the control pipeline and its hazard unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam int CTRL_WIDTH   = 10;
  localparam int ALUOP_HI     = 9;
  localparam int ALUOP_LO     = 8;
  localparam int MEMTOREG_HI  = 7;
  localparam int MEMTOREG_LO  = 6;
  localparam int BRANCH_BIT   = 5;
  localparam int MEMREAD_BIT  = 4;
  localparam int MEMWRITE_BIT = 3;
  localparam int ALUSRC_BIT   = 2;
  localparam int JUMP_BIT     = 1;
  localparam int REGWRITE_BIT = 0;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_BCMP = 2'b01,
    ALUOP_RTYP = 2'b10,
    ALUOP_ITYP = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    MEMTOREG_ALU = 2'b00,
    MEMTOREG_MEM = 2'b01,
    MEMTOREG_PC4 = 2'b10,
    MEMTOREG_IMM = 2'b11
  } memtoreg_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/ctrl_hazard.sv
// ============================================================================
// Module   : ctrl_hazard
// Purpose  : Combinational RAW hazard detection and EX operand forwarding
//            select. Forwarding is built only with CTRL_FORWARD_EN defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_hazard
  import ctrl_pkg::*;
#(
  parameter int XLEN_REG = 5
) (
  input  logic [XLEN_REG-1:0] id_rs1,
  input  logic [XLEN_REG-1:0] id_rs2,
  input  logic                flush,
  input  logic [XLEN_REG-1:0] ex_rd,
`ifdef CTRL_FORWARD_EN
  input  logic                ex_memread,
  input  logic [XLEN_REG-1:0] ex_rs1,
  input  logic [XLEN_REG-1:0] ex_rs2,
  input  logic [XLEN_REG-1:0] wb_rd,
  input  logic                wb_regwrite,
`else
  input  logic                ex_regwrite,
`endif
  input  logic [XLEN_REG-1:0] mem_rd,
  input  logic                mem_regwrite,
  output logic                stall,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b
);

  // Both ID sources are compared whatever the format; x0 never matches.
  function automatic logic id_match(input logic [XLEN_REG-1:0] rd,
                                    input logic [XLEN_REG-1:0] rs1,
                                    input logic [XLEN_REG-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

`ifdef CTRL_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [XLEN_REG-1:0] rs,
                                         input logic                m_we,
                                         input logic [XLEN_REG-1:0] m_rd,
                                         input logic                w_we,
                                         input logic [XLEN_REG-1:0] w_rd);
    if (m_we && (m_rd != '0) && (m_rd == rs))      return FWD_EXMEM;
    else if (w_we && (w_rd != '0) && (w_rd == rs)) return FWD_MEMWB;
    else                                           return FWD_RF;
  endfunction

  logic w_hazard;
  assign w_hazard = ex_memread && id_match(ex_rd, id_rs1, id_rs2);
  assign fwd_a    = fwd_sel(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
  assign fwd_b    = fwd_sel(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
`else
  logic w_hazard;
  assign w_hazard = (ex_regwrite  && id_match(ex_rd,  id_rs1, id_rs2)) ||
                    (mem_regwrite && id_match(mem_rd, id_rs1, id_rs2));
  assign fwd_a    = FWD_RF;
  assign fwd_b    = FWD_RF;
`endif

  // A flushed ID instruction is discarded, so there is nothing to hold.
  assign stall = w_hazard && !flush;

endmodule

`default_nettype wire

// File: rtl/ctrl_pipeline.sv
// ============================================================================
// Module   : ctrl_pipeline
// Purpose  : EX/MEM/WB control-word pipeline with bubble insertion and flush.
//            Optional macro CTRL_FORWARD_EN enables operand forwarding.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int XLEN_REG = 5,
  parameter int CTRL_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CTRL_W-1:0]   id_ctrl,
  input  logic [XLEN_REG-1:0] id_rs1,
  input  logic [XLEN_REG-1:0] id_rs2,
  input  logic [XLEN_REG-1:0] id_rd,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          ex_alu_op,
  output logic                ex_alu_src,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          wb_memtoreg,
  output logic                wb_regwrite,
  output logic [XLEN_REG-1:0] wb_rd,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b
);

  logic [CTRL_W-1:0]   r_ex_ctrl;
  logic [XLEN_REG-1:0] r_ex_rd;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [1:0]          r_mem_memtoreg;
  logic                r_mem_regwrite;
  logic [XLEN_REG-1:0] r_mem_rd;
  logic [1:0]          r_wb_memtoreg;
  logic                r_wb_regwrite;
  logic [XLEN_REG-1:0] r_wb_rd;
  logic                w_stall;
  logic                w_load_id;

  assign w_load_id = !w_stall && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_ctrl <= CTRL_BUBBLE;
      r_ex_rd   <= '0;
    end else if (w_load_id) begin
      r_ex_ctrl <= id_ctrl;
      r_ex_rd   <= id_rd;
    end else begin
      r_ex_ctrl <= CTRL_BUBBLE;
      r_ex_rd   <= '0;
    end
  end

`ifdef CTRL_FORWARD_EN
  logic [XLEN_REG-1:0] r_ex_rs1;
  logic [XLEN_REG-1:0] r_ex_rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rs1 <= '0;
      r_ex_rs2 <= '0;
    end else if (w_load_id) begin
      r_ex_rs1 <= id_rs1;
      r_ex_rs2 <= id_rs2;
    end else begin
      r_ex_rs1 <= '0;
      r_ex_rs2 <= '0;
    end
  end
`endif

  // Downstream stages never stall: they advance every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_memtoreg <= 2'b00;
      r_mem_regwrite <= 1'b0;
      r_mem_rd       <= '0;
      r_wb_memtoreg  <= 2'b00;
      r_wb_regwrite  <= 1'b0;
      r_wb_rd        <= '0;
    end else begin
      r_mem_read     <= r_ex_ctrl[MEMREAD_BIT];
      r_mem_write    <= r_ex_ctrl[MEMWRITE_BIT];
      r_mem_memtoreg <= r_ex_ctrl[MEMTOREG_HI:MEMTOREG_LO];
      r_mem_regwrite <= r_ex_ctrl[REGWRITE_BIT];
      r_mem_rd       <= r_ex_rd;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_rd        <= r_mem_rd;
    end
  end

  ctrl_hazard #(
    .XLEN_REG     (XLEN_REG)
  ) u_hazard (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .flush        (flush),
    .ex_rd        (r_ex_rd),
`ifdef CTRL_FORWARD_EN
    .ex_memread   (r_ex_ctrl[MEMREAD_BIT]),
    .ex_rs1       (r_ex_rs1),
    .ex_rs2       (r_ex_rs2),
    .wb_rd        (r_wb_rd),
    .wb_regwrite  (r_wb_regwrite),
`else
    .ex_regwrite  (r_ex_ctrl[REGWRITE_BIT]),
`endif
    .mem_rd       (r_mem_rd),
    .mem_regwrite (r_mem_regwrite),
    .stall        (w_stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  assign stall       = w_stall;
  assign ex_alu_op   = r_ex_ctrl[ALUOP_HI:ALUOP_LO];
  assign ex_alu_src  = r_ex_ctrl[ALUSRC_BIT];
  assign ex_branch   = r_ex_ctrl[BRANCH_BIT];
  assign ex_jump     = r_ex_ctrl[JUMP_BIT];
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign wb_memtoreg = r_wb_memtoreg;
  assign wb_regwrite = r_wb_regwrite;
  assign wb_rd       = r_wb_rd;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
// ============================================================================
// Module   : tb_ctrl_pipeline
// Purpose  : Self-checking bench: directed scenarios plus random traffic
//            compared against an instruction-level pipeline model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] id_ctrl = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       flush = 1'b0;
  logic       stall;
  logic [1:0] ex_alu_op, wb_memtoreg, fwd_a, fwd_b;
  logic       ex_alu_src, ex_branch, ex_jump, mem_read, mem_write, wb_regwrite;
  logic [4:0] wb_rd;

  always #5 clk = ~clk;

  ctrl_pipeline #(.XLEN_REG(5), .CTRL_W(10)) dut (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .flush(flush), .stall(stall), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .mem_read(mem_read), .mem_write(mem_write), .wb_memtoreg(wb_memtoreg),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  localparam logic [9:0] LW   = 10'b00_01_0_1_0_1_0_1;
  localparam logic [9:0] ADD  = 10'b10_00_0_0_0_0_0_1;
  localparam logic [9:0] ADDI = 10'b11_00_0_0_0_1_0_1;
  localparam logic [9:0] RTYP = 10'b10_11_0_0_0_0_0_1;

`ifdef CTRL_FORWARD_EN
  localparam int LU_STALLS  = 1;
  localparam int RAW_STALLS = 0;
`else
  localparam int LU_STALLS  = 2;
  localparam int RAW_STALLS = 2;
`endif

  // Model: one instruction record per stage, 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    logic [9:0] ctrl;
    logic [4:0] rd, rs1, rs2;
  } instr_t;

  instr_t pipe[3];
  int     n_pass = 0;
  int     n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit writes(input instr_t i, input logic [4:0] r);
    return i.ctrl[0] && (i.rd != 0) && (i.rd == r);
  endfunction

  function automatic bit uses(input instr_t i, input logic [4:0] a, input logic [4:0] b);
    return (i.rd != 0) && ((i.rd == a) || (i.rd == b));
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
`ifdef CTRL_FORWARD_EN
    if (writes(pipe[1], rs)) return 2'b10;
    if (writes(pipe[2], rs)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic bit exp_stall(input logic [4:0] a, input logic [4:0] b, input logic fl);
    bit h;
`ifdef CTRL_FORWARD_EN
    h = pipe[0].ctrl[4] && uses(pipe[0], a, b);
`else
    h = (pipe[0].ctrl[0] && uses(pipe[0], a, b)) || (pipe[1].ctrl[0] && uses(pipe[1], a, b));
`endif
    return h && !fl;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{ctrl: '0, rd: '0, rs1: '0, rs2: '0};
  endfunction

  task automatic step(input logic [9:0] c, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] d, input logic fl, output bit s);
    instr_t nw;
    @(negedge clk);
    id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = d; flush = fl;
    #1;
    s = exp_stall(r1, r2, fl);
    check("stall", {31'd0, stall}, {31'd0, s});
    check("fwd_a", {30'd0, fwd_a}, {30'd0, exp_fwd(pipe[0].rs1)});
    check("fwd_b", {30'd0, fwd_b}, {30'd0, exp_fwd(pipe[0].rs2)});
    check("ex_fields", {27'd0, ex_alu_op, ex_alu_src, ex_branch, ex_jump},
          {27'd0, pipe[0].ctrl[9:8], pipe[0].ctrl[2], pipe[0].ctrl[5], pipe[0].ctrl[1]});
    check("mem_fields", {30'd0, mem_read, mem_write}, {30'd0, pipe[1].ctrl[4], pipe[1].ctrl[3]});
    check("wb_fields", {24'd0, wb_memtoreg, wb_regwrite, wb_rd},
          {24'd0, pipe[2].ctrl[7:6], pipe[2].ctrl[0], pipe[2].rd});
    @(posedge clk);
    nw = '{ctrl: c, rd: d, rs1: r1, rs2: r2};
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (s || fl) pipe[0] = '{ctrl: '0, rd: '0, rs1: '0, rs2: '0};
    else         pipe[0] = nw;
  endtask

  // Presents one instruction, holding it in ID while stalled; returns stall cycles.
  task automatic issue(input logic [9:0] c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input logic fl, output int n);
    bit s;
    n = 0;
    do begin
      step(c, r1, r2, d, fl, s);
      if (s) n++;
    end while (s && n < 4);
    if (s) check("stall_bound", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    id_ctrl = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; flush = 1'b0;
    #1;
    check("reset_outputs", {12'd0, stall, fwd_a, fwd_b, ex_alu_op, ex_alu_src, ex_branch,
          ex_jump, mem_read, mem_write, wb_memtoreg, wb_regwrite, wb_rd}, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit s;
    model_clear();
    do_reset();

    // Passthrough of an R-type word through all three stages.
    issue(RTYP, 5'd1, 5'd2, 5'd5, 1'b0, n);
    repeat (3) issue(10'd0, 5'd0, 5'd0, 5'd0, 1'b0, n);

    // Load-use dependency.
    issue(LW, 5'd0, 5'd0, 5'd7, 1'b0, n);
    issue(ADD, 5'd7, 5'd0, 5'd8, 1'b0, n);
    check("loaduse_stalls", n, LU_STALLS);
    repeat (2) issue(10'd0, 5'd0, 5'd0, 5'd0, 1'b0, n);

    // ALU producer then consumer.
    issue(ADDI, 5'd0, 5'd0, 5'd4, 1'b0, n);
    issue(ADD, 5'd4, 5'd0, 5'd9, 1'b0, n);
    check("raw_stalls", n, RAW_STALLS);

    // Back-to-back writers of x3, then a consumer of x3 and an x0 pair.
    issue(ADDI, 5'd0, 5'd0, 5'd3, 1'b0, n);
    issue(ADDI, 5'd0, 5'd0, 5'd3, 1'b0, n);
    issue(ADD, 5'd1, 5'd3, 5'd10, 1'b0, n);
    issue(ADDI, 5'd0, 5'd0, 5'd0, 1'b0, n);
    issue(ADD, 5'd0, 5'd1, 5'd11, 1'b0, n);
    repeat (3) issue(10'd0, 5'd0, 5'd0, 5'd0, 1'b0, n);

    // Load-use hazard coinciding with a flush.
    issue(LW, 5'd0, 5'd0, 5'd2, 1'b0, n);
    issue(ADD, 5'd2, 5'd2, 5'd6, 1'b1, n);
    check("flush_stall", n, 0);
    issue(10'd0, 5'd0, 5'd0, 5'd0, 1'b0, n);

    // Reset with a load sitting in MEM.
    issue(LW, 5'd0, 5'd0, 5'd12, 1'b0, n);
    issue(10'd0, 5'd0, 5'd0, 5'd0, 1'b0, n);
    do_reset();
    issue(10'd0, 5'd0, 5'd0, 5'd0, 1'b0, n);
    check("post_reset_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else step(10'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
